// File: rtl/matrix_operand_loader_pkg.sv
// Shared constants, state encoding and size helper for the matrix operand loader.
package matrix_operand_loader_pkg;

  localparam int unsigned ELEM_W  = 8;
  localparam int unsigned MAX_DIM = 5;
  localparam int unsigned FLAT_W  = MAX_DIM * MAX_DIM * ELEM_W;
  localparam int unsigned MIN_DIM = 2;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StHold
  } state_e;

  // Number of elements in an n x n matrix; 0 flags an unsupported size.
  function automatic logic [CNT_W-1:0] elem_count(input logic [2:0] size);
    logic [CNT_W-1:0] n_el;
    case (size)
      3'd2:    n_el = 5'd4;
      3'd3:    n_el = 5'd9;
      3'd4:    n_el = 5'd16;
      3'd5:    n_el = 5'd25;
      default: n_el = 5'd0;
    endcase
    return n_el;
  endfunction

endpackage

// File: rtl/matrix_operand_loader.sv
// Packs a byte stream row-major into the flat determinant operand and holds it
// under a valid/ready handshake until the determinant stage takes it.
module matrix_operand_loader
  import matrix_operand_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        size_in,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_data,
  output logic              in_ready,
  output logic [FLAT_W-1:0] A_flat,
  output logic [2:0]        matrix_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              size_error
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [FLAT_W-1:0] a_flat_q;
  logic [2:0]        size_q;
  logic              size_error_q;

  logic              size_legal;
  logic              last_elem;
  logic              accept;

  assign size_legal = (elem_count(size_in) != '0);
  assign last_elem  = (cnt_q == elem_count(size_q) - 5'd1);
  assign accept     = (state_q == StLoad) && in_valid;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (start && size_legal) state_d = StLoad;
        StLoad: if (in_valid && last_elem) state_d = StHold;
        StHold: if (out_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded straight from state so no input reaches them combinationally.
  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StHold);
  end

  // Datapath: size latch, element counter, indexed byte writes, size error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      a_flat_q     <= '0;
      size_q       <= '0;
      size_error_q <= 1'b0;
    end else if (abort) begin
      // Latched size survives an abort; the operand does not.
      cnt_q        <= '0;
      a_flat_q     <= '0;
      size_error_q <= 1'b0;
    end else begin
      size_error_q <= (state_q == StIdle) && start && !size_legal;
      if ((state_q == StIdle) && start && size_legal) begin
        size_q   <= size_in;
        a_flat_q <= '0;
        cnt_q    <= '0;
      end
      if (accept) begin
        for (int unsigned k = 0; k < MAX_DIM * MAX_DIM; k++) begin
          if (cnt_q == CNT_W'(k)) a_flat_q[k*ELEM_W +: ELEM_W] <= in_data;
        end
        // Return to 0 on the last element so the counter never passes 24.
        cnt_q <= last_elem ? '0 : cnt_q + 5'd1;
      end
    end
  end

  assign A_flat      = a_flat_q;
  assign matrix_size = size_q;
  assign size_error  = size_error_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader: directed loads push expected
// operands, a negedge monitor pops and compares when out_valid rises.
module tb_matrix_operand_loader;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start, abort, in_valid, out_ready;
  logic [2:0]   size_in;
  logic [7:0]   in_data;
  logic         in_ready, out_valid, size_error;
  logic [199:0] A_flat;
  logic [2:0]   matrix_size;

  typedef struct packed {
    logic [199:0] flat;
    logic [2:0]   size;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         start_cyc;
  logic       prev_valid = 1'b0;
  logic [7:0] el [25];

  matrix_operand_loader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .size_in     (size_in),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .A_flat      (A_flat),
    .matrix_size (matrix_size),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .size_error  (size_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] pack(input int n_el, input logic [7:0] e [25]);
    logic [199:0] f = '0;
    for (int k = 0; k < n_el; k++) f[8*k +: 8] = e[k];
    return f;
  endfunction

  // Monitor: each new out_valid must match the oldest expected operand.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 200'd1, 200'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_A_flat", A_flat, e.flat);
          check("sb_matrix_size", {197'd0, matrix_size}, {197'd0, e.size});
        end
      end
      prev_valid = out_valid;
    end
  end

  // All tasks are entered and left #1 after a rising edge.
  task automatic do_start(input logic [2:0] s);
    start = 1'b1;
    size_in = s;
    @(posedge clock); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Streams n_el elements; out_valid must stay low until target acceptances.
  task automatic stream(input int n_el, input int target, input bit toggle);
    int idx = 0;
    int phase = 0;
    bit acc;
    while (idx < n_el && phase < 200) begin
      in_valid = toggle ? (phase % 2 == 0) : 1'b1;
      in_data  = el[idx];
      acc      = in_valid && in_ready;
      @(posedge clock); #1;
      phase++;
      in_valid = 1'b0;
      if (acc) begin
        idx++;
        check("out_valid_timing", {199'd0, out_valid}, {199'd0, idx == target});
      end
    end
    if (idx < n_el) check("stream_timeout", 200'(idx), 200'(n_el));
  endtask

  task automatic load(input logic [2:0] s, input bit toggle);
    int n = int'(s) * int'(s);
    exp_q.push_back('{flat: pack(n, el), size: s});
    do_start(s);
    stream(n, n, toggle);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("hs_out_valid", {199'd0, out_valid}, 200'd0);
    check("hs_in_ready", {199'd0, in_ready}, 200'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {199'd0, in_ready}, 200'd0);
    check({tag, "_out_valid"}, {199'd0, out_valid}, 200'd0);
    check({tag, "_size_error"}, {199'd0, size_error}, 200'd0);
    check({tag, "_A_flat"}, A_flat, 200'd0);
    check({tag, "_matrix_size"}, {197'd0, matrix_size}, 200'd0);
  endtask

  task automatic bad_size(input logic [2:0] s);
    do_start(s);
    check("size_error_pulse", {199'd0, size_error}, 200'd1);
    check("bad_size_in_ready", {199'd0, in_ready}, 200'd0);
    @(posedge clock); #1;
    check("size_error_drop", {199'd0, size_error}, 200'd0);
    check("bad_size_idle", {198'd0, in_ready, out_valid}, 200'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    size_in = 3'd0; in_data = 8'd0;
    #12;
    check_reset_values("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 2x2, no stalls: first out_valid n*n edges after the start edge.
    el[0] = 8'd3; el[1] = 8'd8; el[2] = 8'd4; el[3] = 8'd6;
    load(3'd2, 1'b0);
    check("latency_2x2", 200'(cyc - start_cyc), 200'd4);
    check("A_flat_low32", {168'd0, A_flat[31:0]}, 200'h06040803);
    check("A_flat_upper_zero", {32'd0, A_flat[199:32]}, 200'd0);
    check("matrix_size_2", {197'd0, matrix_size}, 200'd2);
    handshake();

    // 5x5 with in_valid every other cycle.
    for (int k = 0; k < 25; k++) el[k] = 8'(k + 1);
    load(3'd5, 1'b1);
    check("A_flat_5x5_last", {192'd0, A_flat[199:192]}, 200'd25);
    handshake();

    // Illegal sizes.
    bad_size(3'd6);
    bad_size(3'd1);

    // HOLD stability while inputs wiggle; start in HOLD is ignored.
    el[0] = 8'h81; el[1] = 8'h7f; el[2] = 8'hff; el[3] = 8'h10;
    load(3'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h20 + i);
      start = (i == 3);
      size_in = 3'd7;
      @(posedge clock); #1;
      check("hold_A_flat", A_flat, 200'h10ff7f81);
      check("hold_flags", {197'd0, in_ready, out_valid, size_error}, 200'b010);
    end
    in_valid = 1'b0; start = 1'b0;
    handshake();

    // 3x3 aborted after 4 elements, abort coinciding with a valid element.
    for (int k = 0; k < 9; k++) el[k] = 8'(8'hf0 + k);
    do_start(3'd3);
    stream(4, 9, 1'b0);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(posedge clock); #1;
    abort = 1'b0; in_valid = 1'b0;
    check("abort_A_flat", A_flat, 200'd0);
    check("abort_idle", {198'd0, in_ready, out_valid}, 200'd0);
    check("abort_size_kept", {197'd0, matrix_size}, 200'd3);
    load(3'd3, 1'b0);
    handshake();

    // Asynchronous reset mid-LOAD.
    for (int k = 0; k < 16; k++) el[k] = 8'(8'h40 + k);
    do_start(3'd4);
    stream(5, 16, 1'b0);
    #3 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    el[0] = 8'h11; el[1] = 8'h22; el[2] = 8'h33; el[3] = 8'h44;
    load(3'd2, 1'b0);
    check("post_reset_A_flat", A_flat, 200'h44332211);
    handshake();

    repeat (2) @(posedge clock);
    #1 check("scoreboard_empty", 200'(exp_q.size()), 200'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Upstream feeder for the determinant ALU. It accepts matrix elements one byte at a time over a valid/ready stream and packs them row-major into the 200-bit flat operand bus. It then holds the packed matrix and its size stable, under a valid/ready handshake, until the determinant stage accepts it. Square sizes 2x2 through 5x5 are supported, and unused operand bits are forced to zero.

## Interface
- ELEM_W, 8: element width in bits
- MAX_DIM, 5: largest supported matrix dimension
- FLAT_W, 200: flat operand width (MAX_DIM*MAX_DIM*ELEM_W)

- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin loading; sampled only in IDLE
- size_in  in  3  matrix dimension for this load; legal values 2..5
- abort  in  1  synchronous cancel; returns the block to IDLE from any state
- in_valid  in  1  in_data carries an element
- in_data  in  8  element, two's-complement, row-major order
- in_ready  out  1  block accepts an element this cycle
- A_flat  out  200  packed matrix; element k at bits [8k+7:8k]
- matrix_size  out  3  latched dimension for the packed matrix
- out_valid  out  1  A_flat/matrix_size are complete and stable
- out_ready  in  1  downstream accepts the matrix
- size_error  out  1  one-cycle pulse: start with illegal size_in

## Operation
- States: IDLE, LOAD, HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - start with size_in in 2..5: latch size, clear A_flat to 0, clear element counter, go to LOAD.
  - start with size_in 0,1,6,7: pulse size_error for one cycle, stay in IDLE, leave A_flat unchanged.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready writes in_data to A_flat[8*cnt +: 8] and increments cnt.
  - Target count is n*n (4, 9, 16, 25).
  - On acceptance of element n*n-1, go to HOLD.
  - in_valid=0 cycles are stalls, with no timeout.
- HOLD:
  - out_valid=1, in_ready=0.
  - A_flat and matrix_size are frozen.
  - out_valid&out_ready: go to IDLE. A_flat keeps its value until the next legal start.
- start outside IDLE is ignored and does not raise size_error.
- abort has priority over everything else, in any state:
  - next state IDLE, cnt=0, out_valid=0.
  - A_flat is cleared to 0.
  - Latched matrix_size is kept.
- Bits above element n*n-1 are always 0 while in HOLD.
- The counter is 5 bits wide and never exceeds 24; there is no wrap-around.

## Timing
- Reset values: state IDLE, in_ready=0, out_valid=0, size_error=0, A_flat=0, matrix_size=0, cnt=0.
- All outputs are registered or are decoded directly from state; there is no combinational path from in_valid or out_ready to any output.
- start at cycle t → in_ready=1 at t+1.
- Last element accepted at cycle t → out_valid=1 at t+1.
- Minimum latency from start to out_valid is 1 + n*n cycles (5, 10, 17, 26).
- Handshake accepted at t → out_valid=0 and state IDLE at t+1. A new start is accepted at t+1 at the earliest.
- Simultaneous abort and in_valid in LOAD: the element is discarded.
- Simultaneous abort and out_ready in HOLD: counts as an abort; the downstream must ignore it, since out_valid drops at t+1.
- Reset asserted mid-LOAD or mid-HOLD: all outputs go to their reset values immediately, asynchronously.

## Structure
- Shared package holds:
  - ELEM_W, MAX_DIM, FLAT_W
  - MIN_DIM=2
  - state enum (IDLE/LOAD/HOLD)
  - function elem_count(size) returning n*n, 0 for illegal sizes
- No sub-module is needed: a single FSM plus a counter and an indexed write into the flat register.

## Test plan
- Reset, then start, size_in=2, elements 3,8,4,6 with no stalls → out_valid at cycle 5 after start; A_flat[31:0]=0x06040803; all upper bits 0; matrix_size=2.
- size_in=5, elements 1..25 with in_valid toggling every other cycle → A_flat[8k+7:8k]=k+1 for k=0..24; out_valid asserted only after the 25th acceptance.
- start with size_in=6, then size_in=1 → size_error pulses one cycle each; in_ready stays 0; state IDLE.
- HOLD with out_ready low for 10 cycles, while in_valid=1 and data changes → A_flat stable, in_ready=0; out_ready=1 → out_valid=0 next cycle.
- size 3, abort after 4 elements → IDLE next cycle, A_flat=0; a following size-3 load of 9 elements completes correctly.
- reset_n pulled low during LOAD, asynchronously mid-cycle → outputs at reset values before the next clock edge; start after release works normally.
